axi_stream_extract_header: RTL and testbench

AXI_STREAM_EXTRACT_HEADER -- requirements
Module: axi_stream_extract_header

---
 rtl/axi_stream_extract_header.sv | 208 ++++++++++++++++++++
 tb/tb_axi_stream_extract_header.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_extract_header.sv
// Splits the first L bytes of each AXI-Stream packet onto a header port and
// forwards the remaining bytes, left-realigned and packed, on a payload port.
module axi_stream_extract_header #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      data_hdr,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  output logic                    short_hdr,
  input  logic                    ready_hdr
);

  // Byte counts range over 0..DATA_BYTE_WD inclusive.
  localparam int unsigned LEN_WD = $clog2(DATA_BYTE_WD + 1);

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    BODY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Keep mask with the k most significant lanes set.
  function automatic logic [DATA_BYTE_WD-1:0] lead_keep(input logic [LEN_WD-1:0] k);
    return ~({DATA_BYTE_WD{1'b1}} >> k);
  endfunction

  // Expand a per-lane keep into a per-bit data mask.
  function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) begin
      m[8*i +: 8] = {8{k[i]}};
    end
    return m;
  endfunction

  // Number of enabled lanes in a keep pattern.
  function automatic logic [LEN_WD-1:0] count_keep(input logic [DATA_BYTE_WD-1:0] k);
    logic [LEN_WD-1:0] c;
    c = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) begin
      c = c + LEN_WD'(k[i]);
    end
    return c;
  endfunction

  state_t                  state, state_d;
  logic [LEN_WD-1:0]       len_q, len_d;
  logic [DATA_WD-1:0]      lo_data_q, lo_data_d;
  logic [LEN_WD-1:0]       lo_cnt_q, lo_cnt_d;

  logic                    valid_hdr_d, short_hdr_d;
  logic [DATA_WD-1:0]      data_hdr_d;
  logic [DATA_BYTE_WD-1:0] keep_hdr_d;
  logic                    valid_out_d, last_out_d;
  logic [DATA_WD-1:0]      data_out_d;
  logic [DATA_BYTE_WD-1:0] keep_out_d;

  logic                    hdr_free, pay_free;
  logic [LEN_WD-1:0]       len_first, len_cur;
  logic [LEN_WD-1:0]       beat_cnt, head_cnt, tail_cnt;
  logic [DATA_WD-1:0]      din, head_data, tail_data, body_data;
  logic [DATA_BYTE_WD-1:0] head_keep, body_keep;

  // Beat slicing: head = first L bytes, tail = bytes L.. realigned to the MSB.
  always_comb begin
    hdr_free  = !valid_hdr || ready_hdr;
    pay_free  = !valid_out || ready_out;
    len_first = LEN_WD'(byte_strip_cnt) + LEN_WD'(1);
    len_cur   = (state == FIRST) ? len_first : len_q;
    beat_cnt  = count_keep(keep_in);
    din       = data_in & lane_mask(keep_in);
    head_keep = keep_in & lead_keep(len_cur);
    head_data = din & lane_mask(lead_keep(len_cur));
    head_cnt  = (beat_cnt > len_cur) ? len_cur : beat_cnt;
    tail_data = din << {len_cur, 3'b000};
    tail_cnt  = (beat_cnt > len_cur) ? (beat_cnt - len_cur) : '0;
    body_data = lo_data_q | (head_data >> {lo_cnt_q, 3'b000});
    body_keep = lead_keep(lo_cnt_q + head_cnt);
  end

  // Next-state, input acceptance and output-slot updates.
  always_comb begin
    state_d     = state;
    len_d       = len_q;
    lo_data_d   = lo_data_q;
    lo_cnt_d    = lo_cnt_q;
    valid_hdr_d = valid_hdr && !ready_hdr;
    data_hdr_d  = data_hdr;
    keep_hdr_d  = keep_hdr;
    short_hdr_d = short_hdr;
    valid_out_d = valid_out && !ready_out;
    data_out_d  = data_out;
    keep_out_d  = keep_out;
    last_out_d  = last_out;
    ready_in    = 1'b0;

    unique case (state)
      FIRST: begin
        ready_in = rst_n && hdr_free && pay_free;
        if (valid_in && ready_in) begin
          len_d       = len_first;
          valid_hdr_d = 1'b1;
          data_hdr_d  = head_data;
          keep_hdr_d  = head_keep;
          short_hdr_d = (beat_cnt < len_cur);
          lo_data_d   = tail_data;
          lo_cnt_d    = tail_cnt;
          if (last_in) begin
            // Single-beat packet: whatever follows the header closes it.
            if (tail_cnt != '0) begin
              valid_out_d = 1'b1;
              data_out_d  = tail_data;
              keep_out_d  = lead_keep(tail_cnt);
              last_out_d  = 1'b1;
            end
          end else begin
            state_d = BODY;
          end
        end
      end

      BODY: begin
        ready_in = rst_n && pay_free;
        if (valid_in && ready_in) begin
          valid_out_d = 1'b1;
          data_out_d  = body_data;
          keep_out_d  = body_keep;
          last_out_d  = 1'b0;
          lo_data_d   = tail_data;
          lo_cnt_d    = tail_cnt;
          if (last_in) begin
            if (tail_cnt == '0) begin
              last_out_d = 1'b1;
              state_d    = FIRST;
            end else begin
              state_d = FLUSH;
            end
          end
        end
      end

      FLUSH: begin
        // Tail of the last beat did not fit; drain it as its own beat.
        if (pay_free) begin
          valid_out_d = 1'b1;
          data_out_d  = lo_data_q;
          keep_out_d  = lead_keep(lo_cnt_q);
          last_out_d  = 1'b1;
          lo_data_d   = '0;
          lo_cnt_d    = '0;
          state_d     = FIRST;
        end
      end

      default: begin
        state_d = FIRST;
      end
    endcase
  end

  // State, leftover and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FIRST;
      len_q     <= '0;
      lo_data_q <= '0;
      lo_cnt_q  <= '0;
      valid_hdr <= 1'b0;
      data_hdr  <= '0;
      keep_hdr  <= '0;
      short_hdr <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      state     <= state_d;
      len_q     <= len_d;
      lo_data_q <= lo_data_d;
      lo_cnt_q  <= lo_cnt_d;
      valid_hdr <= valid_hdr_d;
      data_hdr  <= data_hdr_d;
      keep_hdr  <= keep_hdr_d;
      short_hdr <= short_hdr_d;
      valid_out <= valid_out_d;
      data_out  <= data_out_d;
      keep_out  <= keep_out_d;
      last_out  <= last_out_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Randomized bench for axi_stream_extract_header against a byte-queue model.
module tb_axi_stream_extract_header;

  localparam int unsigned DATA_WD = 32;
  localparam int unsigned DBW     = 4;
  localparam int unsigned BCW     = 2;

  typedef struct packed {
    logic [DATA_WD-1:0] data;
    logic [DBW-1:0]     keep;
    logic               flag;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               valid_in, last_in, ready_in;
  logic [DATA_WD-1:0] data_in;
  logic [DBW-1:0]     keep_in;
  logic [BCW-1:0]     byte_strip_cnt;
  logic               valid_out, last_out, ready_out;
  logic [DATA_WD-1:0] data_out;
  logic [DBW-1:0]     keep_out;
  logic               valid_hdr, short_hdr, ready_hdr;
  logic [DATA_WD-1:0] data_hdr;
  logic [DBW-1:0]     keep_hdr;

  beat_t       exp_hdr_q[$];
  beat_t       exp_pay_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned stall_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          hold_out_low = 1'b0;
  bit          hold_hdr_low = 1'b0;

  always #5 clk = ~clk;

  axi_stream_extract_header #(
    .DATA_WD(DATA_WD), .DATA_BYTE_WD(DBW), .BYTE_CNT_WD(BCW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in), .byte_strip_cnt(byte_strip_cnt),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
    .last_out(last_out), .ready_out(ready_out),
    .valid_hdr(valid_hdr), .data_hdr(data_hdr), .keep_hdr(keep_hdr),
    .short_hdr(short_hdr), .ready_hdr(ready_hdr)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: header = first min(total,L) bytes; payload = rest packed in full beats.
  task automatic model_packet(input int unsigned len, input logic [7:0] bytes[$]);
    beat_t       b;
    int unsigned total, h, idx;
    total = bytes.size();
    h = (total < len) ? total : len;
    b = '0;
    for (int i = 0; i < int'(h); i++) begin
      b.data[DATA_WD-1-8*i -: 8] = bytes[i];
      b.keep[DBW-1-i] = 1'b1;
    end
    b.flag = (total < len);
    exp_hdr_q.push_back(b);
    idx = len;
    while (idx < total) begin
      b = '0;
      for (int j = 0; j < int'(DBW) && idx < total; j++) begin
        b.data[DATA_WD-1-8*j -: 8] = bytes[idx];
        b.keep[DBW-1-j] = 1'b1;
        idx++;
      end
      b.flag = (idx == total);
      exp_pay_q.push_back(b);
    end
  endtask

  task automatic send_beat(input logic [DATA_WD-1:0] d, input logic [DBW-1:0] k,
                           input logic l, input logic [BCW-1:0] bsc);
    int  waited;
    bit  done;
    @(negedge clk);
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l; byte_strip_cnt = bsc;
    waited = 0;
    done = 1'b0;
    while (!done) begin
      #1;
      if (ready_in) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        stall_cnt++;
        @(negedge clk);
        waited++;
        if (waited > 300) begin
          check_eq("send_timeout", 64'(waited), 64'd0);
          valid_in = 1'b0;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  task automatic send_packet(input int unsigned len, input logic [7:0] bytes[$], input bit chk_lat);
    int unsigned total, nbeats, cnt, base;
    logic [DATA_WD-1:0] d;
    logic [DBW-1:0]     k;
    model_packet(len, bytes);
    total  = bytes.size();
    nbeats = (total + DBW - 1) / DBW;
    cnt    = 0;
    for (int b = 0; b < int'(nbeats); b++) begin
      base = b * DBW;
      cnt  = (total - base < DBW) ? (total - base) : DBW;
      d = DATA_WD'($urandom);
      k = '0;
      for (int j = 0; j < int'(cnt); j++) begin
        d[DATA_WD-1-8*j -: 8] = bytes[base + j];
        k[DBW-1-j] = 1'b1;
      end
      send_beat(d, k, (b == int'(nbeats) - 1),
                (b == 0) ? BCW'(len - 1) : BCW'($urandom));
      if (chk_lat && b == 0) begin #1; check_eq("hdr_latency", 64'(valid_hdr), 64'd1); end
      if (chk_lat && b == 1) begin #1; check_eq("pay_latency", 64'(valid_out), 64'd1); end
    end
    if (nbeats > 1 && cnt > len) begin
      #6;
      check_eq("flush_ready_in", 64'(ready_in), 64'd0);
    end
  endtask

  task automatic rand_bytes(input int unsigned n, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < int'(n); i++) q.push_back(8'($urandom));
  endtask

  // Sink ready generation.
  initial begin
    ready_out = 1'b1;
    ready_hdr = 1'b1;
    forever begin
      @(negedge clk);
      ready_out = hold_out_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      ready_hdr = hold_hdr_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Output monitor: scoreboard on handshake, stability while stalled.
  initial begin
    bit           hdr_stall = 1'b0, pay_stall = 1'b0;
    logic [37:0]  hdr_prev = '0, pay_prev = '0;
    beat_t        e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (valid_hdr && ready_hdr) begin
          check_eq("hdr_expected", 64'(exp_hdr_q.size() != 0), 64'd1);
          if (exp_hdr_q.size() != 0) begin
            e = exp_hdr_q.pop_front();
            check_eq("hdr_data", 64'(data_hdr), 64'(e.data));
            check_eq("hdr_keep", 64'(keep_hdr), 64'(e.keep));
            check_eq("hdr_short", 64'(short_hdr), 64'(e.flag));
          end
        end
        if (valid_out && ready_out) begin
          check_eq("pay_expected", 64'(exp_pay_q.size() != 0), 64'd1);
          if (exp_pay_q.size() != 0) begin
            e = exp_pay_q.pop_front();
            check_eq("pay_data", 64'(data_out), 64'(e.data));
            check_eq("pay_keep", 64'(keep_out), 64'(e.keep));
            check_eq("pay_last", 64'(last_out), 64'(e.flag));
          end
        end
        if (hdr_stall)
          check_eq("hdr_stable", 64'({valid_hdr, data_hdr, keep_hdr, short_hdr}), 64'(hdr_prev));
        if (pay_stall)
          check_eq("pay_stable", 64'({valid_out, data_out, keep_out, last_out}), 64'(pay_prev));
        if (valid_out && !ready_out)
          check_eq("ready_in_bp", 64'(ready_in), 64'd0);
      end
      hdr_stall = rst_n && valid_hdr && !ready_hdr;
      pay_stall = rst_n && valid_out && !ready_out;
      hdr_prev  = {valid_hdr, data_hdr, keep_hdr, short_hdr};
      pay_prev  = {valid_out, data_out, keep_out, last_out};
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    int unsigned t;
    t = 0;
    idle(1);
    while ((exp_hdr_q.size() != 0 || exp_pay_q.size() != 0 || valid_out || valid_hdr) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_hdr_q", 64'(exp_hdr_q.size()), 64'd0);
    check_eq("drain_pay_q", 64'(exp_pay_q.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] pk[$];
    rst_n = 1'b0; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    byte_strip_cnt = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_valid_out", 64'(valid_out), 64'd0);
    check_eq("rst_valid_hdr", 64'(valid_hdr), 64'd0);
    check_eq("rst_last_out", 64'(last_out), 64'd0);
    check_eq("rst_short_hdr", 64'(short_hdr), 64'd0);
    check_eq("rst_data_out", 64'(data_out), 64'd0);
    check_eq("rst_keep_out", 64'(keep_out), 64'd0);
    check_eq("rst_data_hdr", 64'(data_hdr), 64'd0);
    check_eq("rst_keep_hdr", 64'(keep_hdr), 64'd0);
    check_eq("rst_ready_in", 64'(ready_in), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed packets
    pk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_packet(2, pk, 1'b0);
    pk = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33};
    send_packet(1, pk, 1'b0);
    rand_bytes(12, pk);
    send_packet(4, pk, 1'b0);
    pk = '{8'hAA, 8'hBB};
    send_packet(3, pk, 1'b0);
    drain();

    // Latency and sustained throughput with sinks always ready
    idle(2);
    stall_cnt = 0;
    rand_bytes(16, pk);
    send_packet(2, pk, 1'b1);
    check_eq("body_stalls", 64'(stall_cnt), 64'd0);
    drain();

    // Backpressure on payload, then on header at the next packet start
    fork
      begin
        rand_bytes(20, pk);
        send_packet(3, pk, 1'b0);
        rand_bytes(9, pk);
        send_packet(1, pk, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        hold_out_low = 1'b1;
        repeat (5) @(negedge clk);
        hold_out_low = 1'b0;
        hold_hdr_low = 1'b1;
        repeat (6) @(negedge clk);
        hold_hdr_low = 1'b0;
      end
    join
    drain();

    // Randomized traffic with random sink readiness
    rand_ready = 1'b1;
    for (int p = 0; p < 60; p++) begin
      rand_bytes($urandom_range(1, 14), pk);
      send_packet($urandom_range(1, 4), pk, 1'b0);
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    drain();

    // Reset in the middle of a packet with both outputs stalled
    hold_out_low = 1'b1;
    hold_hdr_low = 1'b1;
    repeat (2) @(negedge clk);
    send_beat(DATA_WD'($urandom), 4'hF, 1'b0, 2'd1);
    send_beat(DATA_WD'($urandom), 4'hF, 1'b0, 2'd0);
    @(negedge clk);
    valid_in = 1'b0;
    rst_n = 1'b0;
    #2;
    check_eq("midrst_ready_in", 64'(ready_in), 64'd0);
    @(negedge clk);
    #2;
    check_eq("midrst_valid_out", 64'(valid_out), 64'd0);
    check_eq("midrst_valid_hdr", 64'(valid_hdr), 64'd0);
    check_eq("midrst_ready_in2", 64'(ready_in), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_out_low = 1'b0;
    hold_hdr_low = 1'b0;
    rand_bytes(8, pk);
    send_packet(2, pk, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
